bcd_down_timer: RTL and testbench

- Multi-digit, loadable BCD down-counter/timer. It is the count-down counterpart to the team's BCD up-counter chain.
- Counts a preset value down to 0000 on clock-enable ticks and flags terminal count with a one-cycle done pulse.
- Used for countdown displays and timeouts. Output digits drive the existing 7-segment display path directly.

---
 rtl/bcd_down_timer.sv | 177 +++++++++++++++++
 tb/tb_bcd_down_timer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_down_timer.sv
// Loadable multi-digit BCD down-counter with done pulse and pause/resume.
// Optional auto-reload from a shadow register: define BCD_TIMER_AUTO_RELOAD_EN.
module bcd_down_timer #(
    parameter int DIGITS = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_ce,
    input  logic                i_load,
    input  logic [4*DIGITS-1:0] i_load_val,
    input  logic                i_start,
    input  logic                i_pause,
    output logic [4*DIGITS-1:0] o_count,
    output logic                o_zero,
    output logic                o_done,
    output logic                o_running,
    output logic                o_load_err
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t         state_q;
    logic [W-1:0]   count_q;
    logic           done_q;
    logic           running_q;
    logic           load_err_q;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
    logic [W-1:0]   shadow_q;
`endif

    logic [W-1:0]   load_clamp_d;
    logic           load_err_d;
    logic [W-1:0]   count_dec_d;
    logic           dec_zero_d;

    // Clamp every digit above 9 down to 9; MSB of the result flags any clamp.
    function automatic logic [W:0] bcd_clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         err;
        r   = v;
        err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
                err         = 1'b1;
            end
        end
        return {err, r};
    endfunction

    // Single-step BCD decrement with the borrow rippling through every digit.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Datapath helpers for the load and decrement paths.
    always_comb begin
        {load_err_d, load_clamp_d} = bcd_clamp(i_load_val);
        count_dec_d                = bcd_dec(count_q);
        dec_zero_d                 = (count_dec_d == {W{1'b0}});
    end

    // Control FSM with registered count and status outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= {W{1'b0}};
            done_q     <= 1'b0;
            running_q  <= 1'b0;
            load_err_q <= 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
            shadow_q   <= {W{1'b0}};
`endif
        end else begin
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
            if (i_load) begin
                count_q    <= load_clamp_d;
                load_err_q <= load_err_d;
                state_q    <= ST_IDLE;
                running_q  <= 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                shadow_q   <= load_clamp_d;
`endif
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (!i_pause && i_start) begin
                            if (count_q != {W{1'b0}}) begin
                                state_q   <= ST_RUN;
                                running_q <= 1'b1;
                            end else begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (i_pause) begin
                            state_q   <= ST_PAUSED;
                            running_q <= 1'b0;
                        end else if (i_ce) begin
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                            // A zero count in RUN means the previous tick expired; reload now.
                            if (count_q == {W{1'b0}}) begin
                                if (shadow_q != {W{1'b0}}) begin
                                    count_q <= shadow_q;
                                end else begin
                                    state_q   <= ST_DONE;
                                    running_q <= 1'b0;
                                end
                            end else begin
                                count_q <= count_dec_d;
                                if (dec_zero_d) begin
                                    done_q <= 1'b1;
                                    if (shadow_q == {W{1'b0}}) begin
                                        state_q   <= ST_DONE;
                                        running_q <= 1'b0;
                                    end
                                end
                            end
`else
                            count_q <= count_dec_d;
                            if (dec_zero_d) begin
                                done_q    <= 1'b1;
                                state_q   <= ST_DONE;
                                running_q <= 1'b0;
                            end
`endif
                        end
                    end
                    ST_PAUSED: begin
                        if (!i_pause && i_start) begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_DONE;
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        running_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_count    = count_q;
    assign o_zero     = (count_q == {W{1'b0}});
    assign o_done     = done_q;
    assign o_running  = running_q;
    assign o_load_err = load_err_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Self-checking bench for bcd_down_timer: directed scenarios plus random
// stimulus against an integer-valued reference model.
module tb_bcd_down_timer;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

    logic         clk = 1'b0;
    logic         rst_n, ce, load, start, pause;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic         zero, done, running, load_err;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: count kept as a plain integer.
    int m_val = 0, m_state = M_IDLE, m_shadow = 0;
    bit m_done = 1'b0, m_err = 1'b0;

    bcd_down_timer #(.DIGITS(DIGITS)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_load(load),
        .i_load_val(load_val), .i_start(start), .i_pause(pause),
        .o_count(count), .o_zero(zero), .o_done(done),
        .o_running(running), .o_load_err(load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int pow10(input int n);
        int p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    task automatic model_edge();
        int  d, v;
        bit  e;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (!rst_n) begin
            m_val = 0; m_state = M_IDLE; m_shadow = 0;
        end else if (load) begin
            v = 0; e = 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                d = int'(load_val >> (4*i)) & 15;
                if (d > 9) begin d = 9; e = 1'b1; end
                v = v + d * pow10(i);
            end
            m_val = v; m_err = e; m_state = M_IDLE; m_shadow = v;
        end else begin
            case (m_state)
                M_IDLE: if (!pause && start) begin
                    if (m_val != 0) m_state = M_RUN;
                    else begin m_state = M_DONE; m_done = 1'b1; end
                end
                M_RUN: if (pause) m_state = M_PAUSED;
                    else if (ce) begin
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                        if (m_val == 0) begin
                            if (m_shadow != 0) m_val = m_shadow;
                            else m_state = M_DONE;
                        end else begin
                            m_val = m_val - 1;
                            if (m_val == 0) begin
                                m_done = 1'b1;
                                if (m_shadow == 0) m_state = M_DONE;
                            end
                        end
`else
                        m_val = m_val - 1;
                        if (m_val == 0) begin m_done = 1'b1; m_state = M_DONE; end
`endif
                    end
                M_PAUSED: if (!pause && start) m_state = M_RUN;
                default: ;
            endcase
        end
    endtask

    // Advance one clock: update the model from the current inputs, then sample after the edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst_n = 1'b1; ce = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; load_val = '0;
    endtask

    task automatic do_load(input logic [W-1:0] v);
        idle_inputs();
        load = 1'b1; load_val = v;
        step();
        load = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0; load = 1'b1; load_val = 16'h1234; start = 1'b1; ce = 1'b1;
        step(); step();
        idle_inputs();
        n_cmp++;
        if (count !== 16'h0000 || running !== 1'b0 || done !== 1'b0 || load_err !== 1'b0 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: count=%h run=%b done=%b err=%b zero=%b, want 0000 0 0 0 1",
                     count, running, done, load_err, zero);
        end
    endtask

    task automatic test_borrow();
        logic [W-1:0] exp_seq [6];
        exp_seq = '{16'h0103, 16'h0102, 16'h0101, 16'h0100, 16'h0099, 16'h0098};
        do_load(16'h0103);
        start = 1'b1; ce = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (count !== exp_seq[i] || running !== 1'b1) begin
                n_fail++;
                $display("FAIL borrow[%0d]: count=%h run=%b, want %h 1", i, count, running, exp_seq[i]);
            end
            step();
        end
    endtask

    task automatic test_done();
        do_load(16'h0002);
        start = 1'b1; ce = 1'b1;
        step();
        start = 1'b0;
        step();
        n_cmp++;
        if (count !== 16'h0001 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pre: count=%h done=%b, want 0001 0", count, done);
        end
        step();
        n_cmp++;
        if (count !== 16'h0000 || done !== 1'b1 || running !== 1'b0 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL done_hit: count=%h done=%b run=%b zero=%b, want 0000 1 0 1", count, done, running, zero);
        end
        step();
        n_cmp++;
        if (count !== 16'h0000 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_after: count=%h done=%b, want 0000 0", count, done);
        end
        start = 1'b1;
        step(); step();
        start = 1'b0;
        n_cmp++;
        if (count !== 16'h0000 || done !== 1'b0 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL done_restart: count=%h done=%b run=%b, want 0000 0 0", count, done, running);
        end
        // Starting from a zero count goes straight to DONE with a single pulse.
        do_load(16'h0000);
        start = 1'b1;
        step();
        n_cmp++;
        if (done !== 1'b1 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL start_zero: done=%b run=%b, want 1 0", done, running);
        end
        step();
        start = 1'b0;
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL start_zero_once: done=%b, want 0", done);
        end
    endtask

    task automatic test_pause();
        do_load(16'h0050);
        start = 1'b1; ce = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (count !== 16'h0047 || running !== 1'b0) begin
                n_fail++;
                $display("FAIL pause_hold[%0d]: count=%h run=%b, want 0047 0", i, count, running);
            end
        end
        start = 1'b1;
        step();
        n_cmp++;
        if (count !== 16'h0047 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_start_both: count=%h run=%b, want 0047 0", count, running);
        end
        pause = 1'b0;
        step();
        start = 1'b0;
        n_cmp++;
        if (count !== 16'h0047 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL resume_edge: count=%h run=%b, want 0047 1", count, running);
        end
        step();
        n_cmp++;
        if (count !== 16'h0046) begin
            n_fail++;
            $display("FAIL resume_tick: count=%h, want 0046", count);
        end
    endtask

    task automatic test_load_clamp();
        do_load(16'h0A3F);
        n_cmp++;
        if (count !== 16'h0939 || load_err !== 1'b1) begin
            n_fail++;
            $display("FAIL clamp: count=%h err=%b, want 0939 1", count, load_err);
        end
        step();
        n_cmp++;
        if (load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL clamp_pulse: err=%b, want 0", load_err);
        end
        do_load(16'h0012);
        start = 1'b1; ce = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        n_cmp++;
        if (count !== 16'h0010 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL run_at_10: count=%h run=%b, want 0010 1", count, running);
        end
        load = 1'b1; load_val = 16'h0777;
        step();
        load = 1'b0;
        n_cmp++;
        if (count !== 16'h0777 || running !== 1'b0 || load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL load_abort: count=%h run=%b err=%b, want 0777 0 0", count, running, load_err);
        end
        step();
        n_cmp++;
        if (count !== 16'h0777 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: count=%h run=%b, want 0777 0", count, running);
        end
        ce = 1'b0;
    endtask

`ifdef BCD_TIMER_AUTO_RELOAD_EN
    task automatic test_auto_reload();
        int  exp_v [8];
        bit  exp_d [8];
        exp_v = '{3, 2, 1, 0, 3, 2, 1, 0};
        exp_d = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        do_load(16'h0003);
        start = 1'b1; ce = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (count !== to_bcd(exp_v[i]) || done !== exp_d[i] || running !== 1'b1) begin
                n_fail++;
                $display("FAIL auto_reload[%0d]: count=%h done=%b run=%b, want %h %b 1",
                         i, count, done, running, to_bcd(exp_v[i]), exp_d[i]);
            end
            step();
        end
    endtask
`endif

    task automatic test_random();
        logic [W-1:0] raw;
        bit           prev_done;
        prev_done = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 99) >= 2);
            load  = ($urandom_range(0, 99) < 8);
            raw   = W'($urandom);
            if ($urandom_range(0, 9) < 7) raw[W-1:8] = '0;
            load_val = raw;
            start = ($urandom_range(0, 99) < 20);
            pause = ($urandom_range(0, 99) < 8);
            ce    = ($urandom_range(0, 99) < 75);
            step();
            n_cmp++;
            if (count !== to_bcd(m_val) || zero !== (m_val == 0) || done !== m_done ||
                running !== (m_state == M_RUN) || load_err !== m_err) begin
                n_fail++;
                $display("FAIL random[%0d]: count=%h zero=%b done=%b run=%b err=%b, want %h %b %b %b %b",
                         c, count, zero, done, running, load_err, to_bcd(m_val),
                         (m_val == 0), m_done, (m_state == M_RUN), m_err);
            end
            n_cmp++;
            if (prev_done && done) begin
                n_fail++;
                $display("FAIL done_twice[%0d]: done=%b after done=%b, want 0", c, done, prev_done);
            end
            prev_done = done;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_borrow();
        test_done();
        test_pause();
        test_load_clamp();
`ifdef BCD_TIMER_AUTO_RELOAD_EN
        test_auto_reload();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
